mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, word-aligned base of the 16-byte register window.
REQ-002 Parameter PRESCALE_W, default 8, width of the prescaler field and counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled only on posedge clk.
REQ-005 ce  input  1  data-bus chip enable from the core (data_ce_o).
REQ-006 we  input  1  data-bus write enable; 1 = write, 0 = read.
REQ-007 addr  input  32  data-bus byte address.
REQ-008 data_i  input  32  write data from the core.
REQ-009 data_o  output  32  read data to the core.
REQ-010 sel_o  output  1  1 when ce=1 and addr[31:4]==BASE_ADDR[31:4]; used for the SoC read mux.

Function
REQ-011 Registers, selected by addr[3:2] when sel_o=1:
- 0x0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IE, [15:8] PRESCALE; other bits read 0.
- 0x4 COUNT: 32-bit, RW.
- 0x8 CMP: 32-bit, RW.
- 0xC STATUS: [0] MATCH, [1] OVF; write-1-to-clear.
REQ-012 Reads are combinational: data_o = selected register when ce=1, we=0, sel_o=1; otherwise data_o=0.
REQ-013 Writes (ce=1, we=1, sel_o=1) take effect at the next posedge clk; writes outside the window are ignored.
REQ-014 Prescaler counter (PRESCALE_W bits) increments each cycle while EN=1; when it equals PRESCALE, it returns to 0 and a one-cycle tick is asserted; PRESCALE=0 gives a tick every cycle.
REQ-015 While EN=0, the prescaler holds at 0, no ticks occur, and COUNT holds.
REQ-016 Any write to CTRL clears the prescaler counter in the same edge.
REQ-017 On tick: if COUNT==CMP, MATCH<=1 and COUNT<=(AUTO_RELOAD ? 0 : COUNT+1); otherwise COUNT<=COUNT+1.
REQ-018 On tick with COUNT==32'hFFFF_FFFF and no match reload, COUNT wraps to 0 and OVF<=1.
REQ-019 A software write to COUNT in the same cycle as a tick wins; the tick is lost, but the match check still uses the pre-write COUNT.
REQ-020 W1C of a STATUS bit in the same cycle as a hardware set of that bit leaves the bit set (set wins).
REQ-021 Writes to STATUS bits with value 0 have no effect; software cannot set STATUS bits.

Reset
REQ-022 With rst=0 at posedge clk, CTRL, COUNT, CMP, STATUS and the prescaler go to 0; an in-progress count is abandoned.
REQ-023 During reset, data_o follows REQ-012 using reset register values, and writes are ignored.

Configuration
REQ-024 Macro MMIO_TIMER_IRQ_EN defined: adds port irq_o (output, 1 bit) = IE & (MATCH | OVF), combinational from registers, 0 after reset.
REQ-025 Macro MMIO_TIMER_IRQ_EN undefined: port irq_o is absent, CTRL[2] is not stored and reads 0; all other behaviour is identical.

Structure
REQ-026 Shared package soc_pkg holds the register offsets (CTRL/COUNT/CMP/STATUS), CTRL and STATUS bit positions, and the default BASE_ADDR.
REQ-027 The prescaler is sub-module mmio_timer_prescaler (inputs clk, rst, en, clr, div; output tick).

Verification
REQ-028 Reset, then read all four offsets -> data_o=0 for each; sel_o=1 only for addr 0x1000–0x100F.
REQ-029 CMP=5, CTRL=0x0000_0003 (EN, AUTO_RELOAD, PRESCALE=0) -> COUNT runs 0..5; MATCH=1 on the tick at COUNT=5; next COUNT=0.
REQ-030 CTRL=0x0000_0301 (PRESCALE=3) -> COUNT increments once every 4 cycles; clearing EN freezes COUNT.
REQ-031 COUNT=0xFFFF_FFFE, CMP=0, EN=1, PRESCALE=0 -> two ticks later COUNT=0 and OVF=1; a write of 0x2 to STATUS clears OVF.
REQ-032 W1C of MATCH in the same cycle as a match tick -> MATCH remains 1; a COUNT write of 0x10 during a tick -> COUNT=0x10.
REQ-033 With MMIO_TIMER_IRQ_EN defined: IE=1 and MATCH set -> irq_o=1; W1C of MATCH -> irq_o=0 on the next cycle. Assert rst=0 mid-count -> all registers 0 at the next edge.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC constants: timer register word indices, CTRL/STATUS bit positions, default base.
// No logic, no latency; constants only.
package soc_pkg;

    localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_1000;

    // Word index addr[3:2]: CTRL 0x0, COUNT 0x4, CMP 0x8, STATUS 0xC
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AR_BIT    = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int CTRL_PRESC_LSB = 8;

    localparam int STAT_MATCH_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;

endpackage

// File: rtl/mmio_timer_if.sv
// Core data-bus slice seen by the timer: chip enable, write enable, address, write/read data, select.
// Reads are combinational; no backpressure, every access completes in its own cycle.
interface mmio_timer_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        sel_o;

    modport master (output ce, we, addr, data_i, input data_o, sel_o);
    modport slave  (input ce, we, addr, data_i, output data_o, sel_o);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Divides clk by (div+1) while enabled, emitting a one-cycle tick when the count reaches div.
// Tick is combinational from the count register; clr or !en restart the count at 0.
module mmio_timer_prescaler #(
    parameter int PRESCALE_W = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] r_cnt;

    assign tick = en && (r_cnt == div);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || !en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer with prescaler, compare match, overflow and W1C status.
// Reads combinational, writes land next edge, never stalls; MMIO_TIMER_IRQ_EN adds IE and irq_o.
module mmio_timer
    import soc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = TIMER_BASE_ADDR,
    parameter int          PRESCALE_W = 8
)(
    input  logic        clk,
    input  logic        rst,
    mmio_timer_if.slave bus
`ifdef MMIO_TIMER_IRQ_EN
    ,
    output logic        irq_o
`endif
);
    logic                  r_en;
    logic                  r_auto;
    logic [PRESCALE_W-1:0] r_presc;
    logic [31:0]           r_count;
    logic [31:0]           r_cmp;
    logic                  r_match;
    logic                  r_ovf;

    reg_sel_e    w_idx;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_cnt_wr;
    logic        w_cmp_wr;
    logic        w_stat_wr;
    logic        w_tick;
    logic        w_hit;
    logic        w_reload;
    logic        w_ovf_set;
    logic [31:0] w_rd_dat;
    logic        w_unused;

    assign bus.sel_o = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_idx     = reg_sel_e'(bus.addr[3:2]);
    assign w_wr      = bus.ce && bus.we && bus.sel_o;
    assign w_ctrl_wr = w_wr && (w_idx == REG_CTRL);
    assign w_cnt_wr  = w_wr && (w_idx == REG_COUNT);
    assign w_cmp_wr  = w_wr && (w_idx == REG_CMP);
    assign w_stat_wr = w_wr && (w_idx == REG_STATUS);
    assign w_unused  = ^bus.addr[1:0];

    mmio_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (r_en),
        .clr  (w_ctrl_wr),
        .div  (r_presc),
        .tick (w_tick)
    );

    // Match compares the pre-write COUNT even when a software write steals the tick
    assign w_hit     = w_tick && (r_count == r_cmp);
    assign w_reload  = w_hit && r_auto;
    assign w_ovf_set = w_tick && !w_cnt_wr && !w_reload && (r_count == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_presc <= '0;
            r_count <= '0;
            r_cmp   <= '0;
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_en    <= bus.data_i[CTRL_EN_BIT];
                r_auto  <= bus.data_i[CTRL_AR_BIT];
                r_presc <= bus.data_i[CTRL_PRESC_LSB +: PRESCALE_W];
            end
            if (w_cmp_wr) begin
                r_cmp <= bus.data_i;
            end
            if (w_cnt_wr) begin
                r_count <= bus.data_i;
            end else if (w_tick) begin
                r_count <= w_reload ? 32'd0 : r_count + 32'd1;
            end
            // Hardware set beats a simultaneous write-1-to-clear
            r_match <= w_hit     | (r_match & ~(w_stat_wr & bus.data_i[STAT_MATCH_BIT]));
            r_ovf   <= w_ovf_set | (r_ovf   & ~(w_stat_wr & bus.data_i[STAT_OVF_BIT]));
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    logic r_ie;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ie <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_ie <= bus.data_i[CTRL_IE_BIT];
        end
    end

    assign irq_o = r_ie && (r_match || r_ovf);
`endif

    always_comb begin
        w_rd_dat = '0;
        case (w_idx)
            REG_CTRL: begin
                w_rd_dat[CTRL_EN_BIT] = r_en;
                w_rd_dat[CTRL_AR_BIT] = r_auto;
`ifdef MMIO_TIMER_IRQ_EN
                w_rd_dat[CTRL_IE_BIT] = r_ie;
`endif
                w_rd_dat[CTRL_PRESC_LSB +: PRESCALE_W] = r_presc;
            end
            REG_COUNT:  w_rd_dat = r_count;
            REG_CMP:    w_rd_dat = r_cmp;
            REG_STATUS: begin
                w_rd_dat[STAT_MATCH_BIT] = r_match;
                w_rd_dat[STAT_OVF_BIT]   = r_ovf;
            end
            default:    w_rd_dat = '0;
        endcase
    end

    assign bus.data_o = (bus.ce && !bus.we && bus.sel_o) ? w_rd_dat : 32'd0;
endmodule

// File: tb/tb_mmio_timer.sv
// Randomized and directed checks of mmio_timer against a behavioural register/tick model.
module tb_mmio_timer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mmio_timer_if bus();
`ifdef MMIO_TIMER_IRQ_EN
    logic irq_o;
`endif

    mmio_timer #(.BASE_ADDR(32'h0000_1000), .PRESCALE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MMIO_TIMER_IRQ_EN
        ,
        .irq_o (irq_o)
`endif
    );

    // Behavioural model: fields, a tick phase taken modulo (PRESCALE+1), status flags
    bit          m_en, m_ar, m_ie;
    int unsigned m_presc, m_phase;
    logic [31:0] m_count, m_cmp;
    bit          m_match, m_ovf;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rd;
    logic        last_sel;
    logic        last_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] idx);
        logic [31:0] v;
        v = 32'd0;
        case (idx)
            2'd0: begin
                v[0] = m_en;
                v[1] = m_ar;
`ifdef MMIO_TIMER_IRQ_EN
                v[2] = m_ie;
`endif
                v[15:8] = m_presc[7:0];
            end
            2'd1: v = m_count;
            2'd2: v = m_cmp;
            default: begin
                v[0] = m_match;
                v[1] = m_ovf;
            end
        endcase
        return v;
    endfunction

    // One bus cycle: drive after negedge, check outputs, advance model across the posedge
    task automatic op(input bit c, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit          in_win, tick, wr, hit, reload, cnt_wr;
        logic [1:0]  idx;
        bit          n_en, n_ar, n_ie, n_match, n_ovf;
        int unsigned n_presc, n_phase;
        logic [31:0] n_count, n_cmp, exp_rd;
        bus.ce = c; bus.we = w; bus.addr = a; bus.data_i = d;
        #1;
        in_win = (a >= 32'h1000) && (a <= 32'h100F);
        idx    = a[3:2];
        exp_rd = (c && !w && in_win) ? m_read(idx) : 32'd0;
        last_rd  = bus.data_o;
        last_sel = bus.sel_o;
        check_eq("sel_o", {31'd0, bus.sel_o}, {31'd0, c && in_win});
        check_eq("data_o", bus.data_o, exp_rd);
`ifdef MMIO_TIMER_IRQ_EN
        last_irq = irq_o;
        check_eq("irq_o", {31'd0, irq_o}, {31'd0, m_ie && (m_match || m_ovf)});
`endif
        tick   = m_en && (m_phase == m_presc);
        wr     = c && w && in_win;
        hit    = tick && (m_count == m_cmp);
        reload = hit && m_ar;
        cnt_wr = wr && (idx == 2'd1);
        n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_presc = m_presc;
        n_cmp = m_cmp; n_count = m_count;
        if (!m_en || (wr && idx == 2'd0)) n_phase = 0;
        else n_phase = (m_phase + 1) % (m_presc + 1);
        if (wr && idx == 2'd0) begin
            n_en = d[0]; n_ar = d[1]; n_presc = d[15:8];
`ifdef MMIO_TIMER_IRQ_EN
            n_ie = d[2];
`endif
        end
        if (wr && idx == 2'd2) n_cmp = d;
        if (cnt_wr) n_count = d;
        else if (tick) n_count = reload ? 32'd0 : m_count + 32'd1;
        n_match = hit || (m_match && !(wr && idx == 2'd3 && d[0]));
        n_ovf   = (tick && !cnt_wr && !reload && m_count == 32'hFFFF_FFFF)
                  || (m_ovf && !(wr && idx == 2'd3 && d[1]));
        if (!rst) begin
            n_en = 0; n_ar = 0; n_ie = 0; n_presc = 0; n_phase = 0;
            n_count = 0; n_cmp = 0; n_match = 0; n_ovf = 0;
        end
        @(posedge clk);
        m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_presc = n_presc; m_phase = n_phase;
        m_count = n_count; m_cmp = n_cmp; m_match = n_match; m_ovf = n_ovf;
        @(negedge clk);
    endtask

    task automatic rd(input int idx);
        op(1'b1, 1'b0, 32'h1000 + 32'(idx * 4), 32'd0);
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        op(1'b1, 1'b1, 32'h1000 + 32'(idx * 4), d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.data_i = 32'd0;
        m_en = 0; m_ar = 0; m_ie = 0; m_presc = 0; m_phase = 0;
        m_count = 0; m_cmp = 0; m_match = 0; m_ovf = 0;
        last_rd = 0; last_sel = 0; last_irq = 0;
        rst = 1'b0;
        @(negedge clk);
        idle(2);
        wr(1, 32'h55);
        wr(0, 32'h1);
        rst = 1'b1;

        // Reset values and window decode
        for (int i = 0; i < 4; i++) begin
            rd(i);
            check_eq("reset_read", last_rd, 32'd0);
        end
        op(1'b1, 1'b0, 32'h0000_0FFC, 32'd0); check_eq("sel_below", {31'd0, last_sel}, 32'd0);
        op(1'b1, 1'b0, 32'h0000_100F, 32'd0); check_eq("sel_top",   {31'd0, last_sel}, 32'd1);
        op(1'b1, 1'b0, 32'h0000_1010, 32'd0); check_eq("sel_above", {31'd0, last_sel}, 32'd0);
        op(1'b0, 1'b0, 32'h0000_1000, 32'd0); check_eq("sel_no_ce", {31'd0, last_sel}, 32'd0);

        // Auto-reload at CMP=5, prescale 0
        wr(2, 32'd5); wr(0, 32'h3);
        idle(5);
        rd(1); check_eq("ar_count5", last_rd, 32'd5);
        rd(1); check_eq("ar_reload", last_rd, 32'd0);
        rd(3); check_eq("ar_match", last_rd, 32'd1);

        // Prescale 3: one increment per 4 cycles, then freeze
        wr(0, 32'h0); wr(1, 32'h0); wr(3, 32'h3); wr(0, 32'h301);
        idle(8);
        rd(1); check_eq("presc_count", last_rd, 32'd2);
        wr(0, 32'h300);
        idle(10);
        rd(1); check_eq("presc_frozen", last_rd, 32'd2);

        // Overflow wrap and OVF W1C
        wr(2, 32'd0); wr(1, 32'hFFFF_FFFE); wr(3, 32'h3); wr(0, 32'h1);
        idle(2);
        rd(1); check_eq("ovf_wrap", last_rd, 32'd0);
        rd(3); check_eq("ovf_status", last_rd, 32'd3);
        wr(3, 32'h2);
        rd(3); check_eq("ovf_cleared", last_rd, 32'd1);

        // Set beats W1C; COUNT write beats tick
        wr(0, 32'h0); wr(2, 32'd3); wr(1, 32'd3); wr(3, 32'h3); wr(0, 32'h3);
        wr(3, 32'h1);
        rd(3); check_eq("set_wins", last_rd, 32'd1);
        wr(1, 32'h10);
        rd(1); check_eq("cnt_wr_wins", last_rd, 32'h10);

`ifdef MMIO_TIMER_IRQ_EN
        wr(0, 32'h7);
        idle(1); check_eq("irq_set", {31'd0, last_irq}, 32'd1);
        wr(3, 32'h1);
        idle(1); check_eq("irq_clr", {31'd0, last_irq}, 32'd0);
`endif

        // Reset in mid-count
        wr(0, 32'h3);
        idle(3);
        rst = 1'b0; idle(1); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(i);
            check_eq("midrst_read", last_rd, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int          r, ix;
            bit          c, w;
            logic [31:0] a, d;
            r  = $urandom_range(0, 99);
            ix = $urandom_range(0, 3);
            rst = (r < 2) ? 1'b0 : 1'b1;
            c  = ($urandom_range(0, 9) < 8);
            w  = $urandom_range(0, 1) == 1;
            a  = 32'h1000 + 32'(ix * 4) + 32'($urandom_range(0, 3));
            if (r >= 90) a = (r & 1) ? 32'h1010 + 32'($urandom_range(0, 15)) : 32'h0FF0 + 32'($urandom_range(0, 15));
            case (ix)
                0: d = {$urandom_range(0, 65535) << 16} | (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 255));
                1: d = (r < 10) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 2)) : 32'($urandom_range(0, 12));
                2: d = 32'($urandom_range(0, 12));
                default: d = $urandom;
            endcase
            op(c, w, a, d);
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
